// File: rtl/mod15_capture_fifo.sv
// Show-ahead capture FIFO for the mod-15 counter: snapshots the count plus the
// number of 14->0 wraps seen since the previous accepted capture.
module mod15_capture_fifo #(
    parameter int DEPTH  = 8,
    parameter int WRAP_W = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [3:0]                 count_in,
    input  logic                       count_load,
    input  logic                       capture,
    input  logic                       out_ready,
    input  logic                       clear_err,
    output logic                       out_valid,
    output logic [3:0]                 out_count,
    output logic [WRAP_W-1:0]          out_wraps,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overflow,
    output logic                       range_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [3:0]        mem_count [DEPTH];
    logic [WRAP_W-1:0] mem_wraps [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [3:0]        prev_count;
    logic              load_q;
    logic [WRAP_W-1:0] wrap_acc;

    logic              wrap_now;
    logic [WRAP_W-1:0] wrap_sum;
    logic              push;
    logic              pop;
    logic              drop;

    // A 14->0 step that follows a load is the load landing, not a wrap.
    assign wrap_now  = (prev_count == 4'd14) && (count_in == 4'd0) && !load_q;
    assign wrap_sum  = (wrap_now && (wrap_acc != WRAP_MAX)) ? wrap_acc + WRAP_W'(1) : wrap_acc;

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    assign out_count = out_valid ? mem_count[rd_ptr] : 4'd0;
    assign out_wraps = out_valid ? mem_wraps[rd_ptr] : '0;

    // NOTE: storage has no reset; empty entries are never visible because the
    // head outputs are masked by out_valid, so only pointers/level need clearing.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_count[wr_ptr] <= count_in;
            mem_wraps[wr_ptr] <= wrap_sum;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            prev_count <= 4'd0;
            load_q     <= 1'b0;
            wrap_acc   <= '0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            prev_count <= count_in;
            load_q     <= count_load;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end

            // A dropped capture leaves the accumulator running.
            wrap_acc <= push ? '0 : wrap_sum;

            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end

            if (count_in == 4'd15) begin
                range_err <= 1'b1;
            end else if (clear_err) begin
                range_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod15_capture_fifo.sv
// Directed bench for mod15_capture_fifo: capture, wrap counting, load
// suppression, full/overflow, error flags and asynchronous reset.
module tb_mod15_capture_fifo;

    logic       clock;
    logic       resetn;
    logic [3:0] count_in;
    logic       count_load;
    logic       capture;
    logic       out_ready;
    logic       clear_err;
    logic       out_valid;
    logic [3:0] out_count;
    logic [3:0] out_wraps;
    logic [3:0] level;
    logic       full;
    logic       overflow;
    logic       range_err;

    int checks = 0;
    int errors = 0;

    mod15_capture_fifo #(.DEPTH(8), .WRAP_W(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .count_in   (count_in),
        .count_load (count_load),
        .capture    (capture),
        .out_ready  (out_ready),
        .clear_err  (clear_err),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .out_wraps  (out_wraps),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .range_err  (range_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, clock it, and settle just after the edge.
    task automatic cyc(input logic [3:0] cnt, input logic cap, input logic rdy,
                       input logic ld, input logic clr);
        count_in   = cnt;
        capture    = cap;
        out_ready  = rdy;
        count_load = ld;
        clear_err  = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int from, input int to);
        for (int c = from; c <= to; c++) begin
            cyc(4'(c), 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_head(input string tag, input logic v, input logic [3:0] c,
                              input logic [3:0] w, input logic [3:0] lvl);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".count"}, 32'(out_count), 32'(c));
        check({tag, ".wraps"}, 32'(out_wraps), 32'(w));
        check({tag, ".level"}, 32'(level), 32'(lvl));
    endtask

    logic [3:0] drain_exp [8];

    initial begin
        resetn = 1'b0;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_head("reset", 1'b0, 4'd0, 4'd0, 4'd0);
        check("reset.full", 32'(full), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.range_err", 32'(range_err), 32'd0);
        resetn = 1'b1;

        // out_ready while empty must not underflow
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("underflow.level", 32'(level), 32'd0);

        // basic capture at count 3
        run(1, 2);
        cyc(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_head("basic", 1'b1, 4'd3, 4'd0, 4'd1);
        run(4, 5);
        check_head("basic_hold", 1'b1, 4'd3, 4'd0, 4'd1);
        cyc(4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        check_head("basic_pop", 1'b0, 4'd0, 4'd0, 4'd0);

        // two natural wraps, then capture at 7 -> {7,2}
        run(6, 14);
        run(0, 14);
        run(0, 6);
        cyc(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check_head("wrap2", 1'b1, 4'd7, 4'd2, 4'd1);
        cyc(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        check_head("wrap2_second", 1'b1, 4'd7, 4'd2, 4'd2);
        cyc(4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        check_head("wrap_cleared", 1'b1, 4'd8, 4'd0, 4'd1);
        cyc(4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        check_head("wrap_drained", 1'b0, 4'd0, 4'd0, 4'd0);

        // load at 14 loading 0: no wrap counted
        run(10, 13);
        cyc(4'd14, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_head("load_supp", 1'b1, 4'd0, 4'd0, 4'd1);
        cyc(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        // natural wrap in the capture cycle itself is counted
        run(2, 13);
        cyc(4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_head("same_cycle_wrap", 1'b1, 4'd0, 4'd1, 4'd1);
        cyc(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("same_cycle_wrap.level", 32'(level), 32'd0);

        // fill with 2..9, 9th capture (10) dropped
        for (int c = 2; c <= 9; c++) begin
            cyc(4'(c), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("fill.level", 32'(level), 32'd8);
        check("fill.full", 32'(full), 32'd1);
        check("fill.overflow", 32'(overflow), 32'd0);
        cyc(4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("drop.level", 32'(level), 32'd8);
        check("drop.overflow", 32'(overflow), 32'd1);
        check("drop.head", 32'(out_count), 32'd2);
        // push+pop while full
        cyc(4'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        check("fullpp.level", 32'(level), 32'd8);
        check("fullpp.full", 32'(full), 32'd1);
        check("fullpp.overflow", 32'(overflow), 32'd1);
        drain_exp = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.count", i), 32'(out_count), 32'(drain_exp[i]));
            check($sformatf("drain%0d.wraps", i), 32'(out_wraps), 32'd0);
            cyc(4'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_head("drained", 1'b0, 4'd0, 4'd0, 4'd0);
        cyc(4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);

        // range error: 15 captured verbatim, clear, set-wins
        cyc(4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        check("range.flag", 32'(range_err), 32'd1);
        check_head("range.entry", 1'b1, 4'd15, 4'd0, 4'd1);
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("range.cleared", 32'(range_err), 32'd0);
        check("range.no_wrap_from_15", 32'(level), 32'd2);
        cyc(4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        check("range.set_wins", 32'(range_err), 32'd1);
        cyc(4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("range.cleared2", 32'(range_err), 32'd0);
        cyc(4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check_head("mid_drain", 1'b1, 4'd0, 4'd0, 4'd1);

        // asynchronous reset mid-drain
        #2;
        resetn = 1'b0;
        #1;
        check_head("async_rst", 1'b0, 4'd0, 4'd0, 4'd0);
        check("async_rst.full", 32'(full), 32'd0);
        check("async_rst.overflow", 32'(overflow), 32'd0);
        check("async_rst.range_err", 32'(range_err), 32'd0);
        cyc(4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        cyc(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_head("post_rst", 1'b1, 4'd5, 4'd0, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
